iob_cache_perf_cnt: RTL and testbench
=====================================

# iob_cache_perf_cnt

Performance-counter stage feeding the cache control/status register bank. It counts single-cycle read/write hit/miss events from the cache back-end and keeps six counters: read hit, read miss, write hit, write miss, RW hit and RW miss. It serves each counter through the register bank's per-register read handshake (ren/rdata/rvalid/rready). It also consumes the register bank's RST_CNTRS write strobe to clear all counters.

## Interface
- CNT_W, 32, counter width in bits; legal range 1..32; rdata outputs zero-extended to 32 bits.
- clk_i  in  1  clock; all logic on the rising edge.
- cke_i  in  1  clock enable; when low, all registers hold, including the reset action.
- rst_n_i  in  1  reset, synchronous, active-low.
- read_hit_i, read_miss_i, write_hit_i, write_miss_i  in  1 each  event pulses; each high cycle counts as one event; any combination may be high in the same cycle.
- RST_CNTRS_wdata_i  in  1  clear request data; 1 clears, 0 does nothing.
- RST_CNTRS_wen_i  in  1  clear request strobe.
- RST_CNTRS_wready_o  out  1  clear-request ready.
- X_ren_i  in  1  read request for counter X, where X is one of {RW_HIT, RW_MISS, READ_HIT, READ_MISS, WRITE_HIT, WRITE_MISS}.
- X_rdata_o  out  32  value read from counter X.
- X_rvalid_o  out  1  X_rdata_o is valid.
- X_rready_o  out  1  counter X accepts a read.

## Operation
- Counters are CNT_W-bit registers, updated every cycle with cke_i=1:
  - READ_HIT += read_hit_i; READ_MISS += read_miss_i.
  - WRITE_HIT += write_hit_i; WRITE_MISS += write_miss_i.
  - RW_HIT += read_hit_i + write_hit_i (increment 0, 1 or 2).
  - RW_MISS += read_miss_i + write_miss_i (increment 0, 1 or 2).
- Arithmetic is modulo 2^CNT_W by default; see Configuration.
- Clear: RST_CNTRS_wen_i=1 with RST_CNTRS_wdata_i=1 sets all six counters to 0 at the next edge.
  - Events in the clear cycle are dropped; clear wins.
  - wen=1 with wdata=0 has no effect.
- Read, per counter X, with no shared state between counters:
  - X_ren_i=1 in cycle N captures the counter's current registered value (the value before cycle N's increment or clear) into the X_rdata_o register.
  - X_rvalid_o is high in cycle N+1.
  - X_rdata_o holds until the next X_ren_i.
- Back-to-back ren in cycles N and N+1 produces rvalid in N+1 and N+2, each carrying its own snapshot.
- ren for several counters in the same cycle is served independently and in parallel.
- X_rready_o and RST_CNTRS_wready_o are 1 in every cycle outside reset; the block never stalls.
- No state machine beyond the per-counter rvalid flop; counters always run, including while a read is pending.

## Timing
- Reset (rst_n_i=0 at an edge with cke_i=1):
  - all counters = 0, all X_rdata_o = 0, all X_rvalid_o = 0.
  - all X_rready_o = 0, RST_CNTRS_wready_o = 0.
- Ready outputs go to 1 on the first edge with rst_n_i=1.
- Reset mid-read: a pending rvalid is cancelled and no rvalid is issued for the aborted request.
- Event-to-count latency: 1 cycle. An event in cycle N is visible to a ren issued in cycle N+1.
- Read latency: ren to rvalid is exactly 1 cycle. rvalid is a single-cycle pulse per ren.
- Clear-to-zero latency: 1 cycle. A ren in the clear cycle returns the pre-clear value; a ren in the next cycle returns 0.
- cke_i=0 freezes all state and outputs. Events and requests presented while cke_i=0 are lost.

## Configuration
- IOB_CACHE_PERF_CNT_SATURATE_EN defined: counters saturate at 2^CNT_W-1.
  - An increment of 1 or 2 that would overflow yields the all-ones value.
  - Example: RW_HIT=0xFFFFFFFE with increment 2 gives 0xFFFFFFFF.
  - A saturated counter stays all-ones until it is cleared.
- Macro undefined: modulo wrap. Example: 0xFFFFFFFF + 1 gives 0x00000000; 0xFFFFFFFF + 2 gives 0x00000001.

## Test plan
- Reset check: after reset, each X_ren_i pulse -> X_rvalid_o one cycle later with X_rdata_o=0; all ready outputs are 1 after reset release.
- Counting: 5 read_hit, 3 read_miss, 4 write_hit, 2 write_miss pulses with no overlap -> READ_HIT=5, READ_MISS=3, WRITE_HIT=4, WRITE_MISS=2, RW_HIT=9, RW_MISS=5.
- Simultaneous events: 10 cycles with all four events high -> each single counter=10, RW_HIT=20, RW_MISS=20.
- Clear races:
  - clear asserted in the same cycle as read_hit and RW_HIT_ren with RW_HIT=7 -> rdata=7; the next ren returns 0 (that event dropped).
  - wen with wdata=0 -> counters unchanged.
- Overflow: CNT_W=4, RW_MISS=14, one cycle with both miss inputs high -> 0 and 1 wrap, 15 with IOB_CACHE_PERF_CNT_SATURATE_EN; a further miss keeps 15.
- Reset mid-read: X_ren_i in cycle N, rst_n_i low in cycle N -> no rvalid in N+1; rdata=0 and rready=0 after the reset edge.

Source files
------------

// File: rtl/iob_cache_perf_cnt_if.sv
// ----------------------------------------------------------------------------
// iob_cache_perf_cnt_if
// Groups the signals between the cache back-end / CSR bank and the
// performance-counter stage into one bundle.
//   Event pulses   : read_hit_i, read_miss_i, write_hit_i, write_miss_i
//   Clear request  : RST_CNTRS_wdata_i, RST_CNTRS_wen_i, RST_CNTRS_wready_o
//   Per-counter read handshake, X in {RW_HIT, RW_MISS, READ_HIT, READ_MISS,
//   WRITE_HIT, WRITE_MISS}: X_ren_i, X_rdata_o[31:0], X_rvalid_o, X_rready_o
// Modports: slave  = the counter block, master = the side driving it.
// ----------------------------------------------------------------------------
interface iob_cache_perf_cnt_if;
   logic        read_hit_i;
   logic        read_miss_i;
   logic        write_hit_i;
   logic        write_miss_i;
   logic        RST_CNTRS_wdata_i;
   logic        RST_CNTRS_wen_i;
   logic        RST_CNTRS_wready_o;
   logic        RW_HIT_ren_i;
   logic [31:0] RW_HIT_rdata_o;
   logic        RW_HIT_rvalid_o;
   logic        RW_HIT_rready_o;
   logic        RW_MISS_ren_i;
   logic [31:0] RW_MISS_rdata_o;
   logic        RW_MISS_rvalid_o;
   logic        RW_MISS_rready_o;
   logic        READ_HIT_ren_i;
   logic [31:0] READ_HIT_rdata_o;
   logic        READ_HIT_rvalid_o;
   logic        READ_HIT_rready_o;
   logic        READ_MISS_ren_i;
   logic [31:0] READ_MISS_rdata_o;
   logic        READ_MISS_rvalid_o;
   logic        READ_MISS_rready_o;
   logic        WRITE_HIT_ren_i;
   logic [31:0] WRITE_HIT_rdata_o;
   logic        WRITE_HIT_rvalid_o;
   logic        WRITE_HIT_rready_o;
   logic        WRITE_MISS_ren_i;
   logic [31:0] WRITE_MISS_rdata_o;
   logic        WRITE_MISS_rvalid_o;
   logic        WRITE_MISS_rready_o;

   modport slave (
      input  read_hit_i, read_miss_i, write_hit_i, write_miss_i,
      input  RST_CNTRS_wdata_i, RST_CNTRS_wen_i,
      output RST_CNTRS_wready_o,
      input  RW_HIT_ren_i,     output RW_HIT_rdata_o,     RW_HIT_rvalid_o,     RW_HIT_rready_o,
      input  RW_MISS_ren_i,    output RW_MISS_rdata_o,    RW_MISS_rvalid_o,    RW_MISS_rready_o,
      input  READ_HIT_ren_i,   output READ_HIT_rdata_o,   READ_HIT_rvalid_o,   READ_HIT_rready_o,
      input  READ_MISS_ren_i,  output READ_MISS_rdata_o,  READ_MISS_rvalid_o,  READ_MISS_rready_o,
      input  WRITE_HIT_ren_i,  output WRITE_HIT_rdata_o,  WRITE_HIT_rvalid_o,  WRITE_HIT_rready_o,
      input  WRITE_MISS_ren_i, output WRITE_MISS_rdata_o, WRITE_MISS_rvalid_o, WRITE_MISS_rready_o
   );

   modport master (
      output read_hit_i, read_miss_i, write_hit_i, write_miss_i,
      output RST_CNTRS_wdata_i, RST_CNTRS_wen_i,
      input  RST_CNTRS_wready_o,
      output RW_HIT_ren_i,     input RW_HIT_rdata_o,     RW_HIT_rvalid_o,     RW_HIT_rready_o,
      output RW_MISS_ren_i,    input RW_MISS_rdata_o,    RW_MISS_rvalid_o,    RW_MISS_rready_o,
      output READ_HIT_ren_i,   input READ_HIT_rdata_o,   READ_HIT_rvalid_o,   READ_HIT_rready_o,
      output READ_MISS_ren_i,  input READ_MISS_rdata_o,  READ_MISS_rvalid_o,  READ_MISS_rready_o,
      output WRITE_HIT_ren_i,  input WRITE_HIT_rdata_o,  WRITE_HIT_rvalid_o,  WRITE_HIT_rready_o,
      output WRITE_MISS_ren_i, input WRITE_MISS_rdata_o, WRITE_MISS_rvalid_o, WRITE_MISS_rready_o
   );
endinterface

// File: rtl/iob_cache_perf_cnt.sv
// ----------------------------------------------------------------------------
// iob_cache_perf_cnt
// Six cache performance counters (RW hit/miss, read hit/miss, write hit/miss)
// with a one-cycle snapshot read port per counter and a global clear.
// Ports:
//   clk_i    : clock, rising edge
//   cke_i    : clock enable, low freezes every register (reset included)
//   rst_n_i  : synchronous active-low reset
//   bus      : iob_cache_perf_cnt_if.slave (events, clear, read handshakes)
// Parameter:
//   CNT_W    : counter width 1..32, read data zero-extended to 32 bits
// Build option:
//   IOB_CACHE_PERF_CNT_SATURATE_EN : counters saturate at all-ones instead
//                                    of wrapping modulo 2^CNT_W.
// Counter index map: 0 RW_HIT, 1 RW_MISS, 2 READ_HIT, 3 READ_MISS,
//                    4 WRITE_HIT, 5 WRITE_MISS.
// ----------------------------------------------------------------------------
module iob_cache_perf_cnt #(
   parameter int CNT_W = 32
) (
   input logic                  clk_i,
   input logic                  cke_i,
   input logic                  rst_n_i,
   iob_cache_perf_cnt_if.slave  bus
);

   localparam int N_CNT = 6;

   logic [N_CNT-1:0] w_ren;
   logic             w_clr;
   logic [1:0]       w_inc   [N_CNT];
   logic [CNT_W-1:0] r_cnt   [N_CNT];
   logic [CNT_W-1:0] r_rdata [N_CNT];
   logic [N_CNT-1:0] r_rvalid;
   logic             r_ready;

   // Counter plus an increment of 0..2, wrapping or saturating.
   function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
`ifdef IOB_CACHE_PERF_CNT_SATURATE_EN
      logic [CNT_W:0] v_sum;
      // One extra bit catches the carry out of the counter.
      v_sum = {1'b0, a} + (CNT_W+1)'(inc);
      f_next = v_sum[CNT_W] ? {CNT_W{1'b1}} : v_sum[CNT_W-1:0];
`else
      f_next = a + CNT_W'(inc);
`endif
   endfunction

   assign w_ren = {bus.WRITE_MISS_ren_i, bus.WRITE_HIT_ren_i,
                   bus.READ_MISS_ren_i,  bus.READ_HIT_ren_i,
                   bus.RW_MISS_ren_i,    bus.RW_HIT_ren_i};

   // Only a strobe carrying a 1 clears; wdata=0 writes are ignored.
   assign w_clr = bus.RST_CNTRS_wen_i & bus.RST_CNTRS_wdata_i;

   // Per-counter increment; the combined counters can step by 2 per cycle.
   always_comb begin
      w_inc[0] = {1'b0, bus.read_hit_i}  + {1'b0, bus.write_hit_i};
      w_inc[1] = {1'b0, bus.read_miss_i} + {1'b0, bus.write_miss_i};
      w_inc[2] = {1'b0, bus.read_hit_i};
      w_inc[3] = {1'b0, bus.read_miss_i};
      w_inc[4] = {1'b0, bus.write_hit_i};
      w_inc[5] = {1'b0, bus.write_miss_i};
   end

   // Counters, read snapshots, rvalid pulses and ready flag.
   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (!rst_n_i) begin
            for (int i = 0; i < N_CNT; i++) begin
               r_cnt[i]   <= '0;
               r_rdata[i] <= '0;
            end
            r_rvalid <= '0;
            r_ready  <= 1'b0;
         end else begin
            r_ready  <= 1'b1;
            r_rvalid <= w_ren;
            for (int i = 0; i < N_CNT; i++) begin
               // Snapshot is the value before this cycle's update.
               if (w_ren[i]) begin
                  r_rdata[i] <= r_cnt[i];
               end
               // Clear wins over any event in the same cycle.
               if (w_clr) begin
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= f_next(r_cnt[i], w_inc[i]);
               end
            end
         end
      end
   end

   assign bus.RST_CNTRS_wready_o  = r_ready;

   assign bus.RW_HIT_rdata_o      = 32'(r_rdata[0]);
   assign bus.RW_HIT_rvalid_o     = r_rvalid[0];
   assign bus.RW_HIT_rready_o     = r_ready;
   assign bus.RW_MISS_rdata_o     = 32'(r_rdata[1]);
   assign bus.RW_MISS_rvalid_o    = r_rvalid[1];
   assign bus.RW_MISS_rready_o    = r_ready;
   assign bus.READ_HIT_rdata_o    = 32'(r_rdata[2]);
   assign bus.READ_HIT_rvalid_o   = r_rvalid[2];
   assign bus.READ_HIT_rready_o   = r_ready;
   assign bus.READ_MISS_rdata_o   = 32'(r_rdata[3]);
   assign bus.READ_MISS_rvalid_o  = r_rvalid[3];
   assign bus.READ_MISS_rready_o  = r_ready;
   assign bus.WRITE_HIT_rdata_o   = 32'(r_rdata[4]);
   assign bus.WRITE_HIT_rvalid_o  = r_rvalid[4];
   assign bus.WRITE_HIT_rready_o  = r_ready;
   assign bus.WRITE_MISS_rdata_o  = 32'(r_rdata[5]);
   assign bus.WRITE_MISS_rvalid_o = r_rvalid[5];
   assign bus.WRITE_MISS_rready_o = r_ready;

endmodule

// File: tb/tb_iob_cache_perf_cnt.sv
// ----------------------------------------------------------------------------
// tb_iob_cache_perf_cnt
// Drives a 32-bit and a 4-bit counter instance with identical stimulus and
// compares every output each cycle against a reference model that tracks
// the counts as plain integers. Directed steps cover reset, counting,
// simultaneous events, clear races, overflow and reset during a read; a
// randomized phase mixes events, reads, clears, cke gaps and resets.
// Counter index map: 0 RW_HIT, 1 RW_MISS, 2 READ_HIT, 3 READ_MISS,
//                    4 WRITE_HIT, 5 WRITE_MISS.
// ----------------------------------------------------------------------------
module tb_iob_cache_perf_cnt;

   logic       clk = 1'b0;
   logic       cke, rst_n;
   logic       rh, rm, wh, wm, clr_wen, clr_wdata;
   logic [5:0] ren;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   iob_cache_perf_cnt_if u_if32 ();
   iob_cache_perf_cnt_if u_if4 ();

   iob_cache_perf_cnt #(.CNT_W(32)) u_dut32 (
      .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .bus(u_if32.slave));
   iob_cache_perf_cnt #(.CNT_W(4)) u_dut4 (
      .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .bus(u_if4.slave));

   always #5 clk = ~clk;

   // Same stimulus into both instances.
   assign u_if32.read_hit_i = rh;   assign u_if4.read_hit_i = rh;
   assign u_if32.read_miss_i = rm;  assign u_if4.read_miss_i = rm;
   assign u_if32.write_hit_i = wh;  assign u_if4.write_hit_i = wh;
   assign u_if32.write_miss_i = wm; assign u_if4.write_miss_i = wm;
   assign u_if32.RST_CNTRS_wen_i = clr_wen;     assign u_if4.RST_CNTRS_wen_i = clr_wen;
   assign u_if32.RST_CNTRS_wdata_i = clr_wdata; assign u_if4.RST_CNTRS_wdata_i = clr_wdata;
   assign u_if32.RW_HIT_ren_i = ren[0];     assign u_if4.RW_HIT_ren_i = ren[0];
   assign u_if32.RW_MISS_ren_i = ren[1];    assign u_if4.RW_MISS_ren_i = ren[1];
   assign u_if32.READ_HIT_ren_i = ren[2];   assign u_if4.READ_HIT_ren_i = ren[2];
   assign u_if32.READ_MISS_ren_i = ren[3];  assign u_if4.READ_MISS_ren_i = ren[3];
   assign u_if32.WRITE_HIT_ren_i = ren[4];  assign u_if4.WRITE_HIT_ren_i = ren[4];
   assign u_if32.WRITE_MISS_ren_i = ren[5]; assign u_if4.WRITE_MISS_ren_i = ren[5];

   // Observed outputs, [0] = 32-bit instance, [1] = 4-bit instance.
   logic [31:0] d_rd [2][6];
   logic [5:0]  d_rv [2];
   logic [5:0]  d_rr [2];
   logic        d_wr [2];

   assign d_rd[0][0] = u_if32.RW_HIT_rdata_o;     assign d_rd[1][0] = u_if4.RW_HIT_rdata_o;
   assign d_rd[0][1] = u_if32.RW_MISS_rdata_o;    assign d_rd[1][1] = u_if4.RW_MISS_rdata_o;
   assign d_rd[0][2] = u_if32.READ_HIT_rdata_o;   assign d_rd[1][2] = u_if4.READ_HIT_rdata_o;
   assign d_rd[0][3] = u_if32.READ_MISS_rdata_o;  assign d_rd[1][3] = u_if4.READ_MISS_rdata_o;
   assign d_rd[0][4] = u_if32.WRITE_HIT_rdata_o;  assign d_rd[1][4] = u_if4.WRITE_HIT_rdata_o;
   assign d_rd[0][5] = u_if32.WRITE_MISS_rdata_o; assign d_rd[1][5] = u_if4.WRITE_MISS_rdata_o;
   assign d_rv[0] = {u_if32.WRITE_MISS_rvalid_o, u_if32.WRITE_HIT_rvalid_o, u_if32.READ_MISS_rvalid_o,
                     u_if32.READ_HIT_rvalid_o, u_if32.RW_MISS_rvalid_o, u_if32.RW_HIT_rvalid_o};
   assign d_rv[1] = {u_if4.WRITE_MISS_rvalid_o, u_if4.WRITE_HIT_rvalid_o, u_if4.READ_MISS_rvalid_o,
                     u_if4.READ_HIT_rvalid_o, u_if4.RW_MISS_rvalid_o, u_if4.RW_HIT_rvalid_o};
   assign d_rr[0] = {u_if32.WRITE_MISS_rready_o, u_if32.WRITE_HIT_rready_o, u_if32.READ_MISS_rready_o,
                     u_if32.READ_HIT_rready_o, u_if32.RW_MISS_rready_o, u_if32.RW_HIT_rready_o};
   assign d_rr[1] = {u_if4.WRITE_MISS_rready_o, u_if4.WRITE_HIT_rready_o, u_if4.READ_MISS_rready_o,
                     u_if4.READ_HIT_rready_o, u_if4.RW_MISS_rready_o, u_if4.RW_HIT_rready_o};
   assign d_wr[0] = u_if32.RST_CNTRS_wready_o;
   assign d_wr[1] = u_if4.RST_CNTRS_wready_o;

   // Reference model state.
   longint unsigned m_cnt [2][6];
   logic [31:0]     m_rd  [2][6];
   logic [5:0]      m_rv  [2];
   logic            m_rdy [2];
   int              m_w   [2] = '{32, 4};

   // Count plus increment for a w-bit counter, wrapping or saturating.
   function automatic longint unsigned model_add(input longint unsigned a,
                                                 input int inc, input int w);
      longint unsigned lim;
      longint unsigned s;
      lim = 64'd1 << w;
      s   = a + longint'(inc);
`ifdef IOB_CACHE_PERF_CNT_SATURATE_EN
      if (s > lim - 64'd1) s = lim - 64'd1;
`else
      s = s % lim;
`endif
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: advance model with the current inputs, then compare all outputs.
   task automatic step();
      int   inc [6];
      logic clr;
      inc[0] = int'(rh) + int'(wh);
      inc[1] = int'(rm) + int'(wm);
      inc[2] = int'(rh);
      inc[3] = int'(rm);
      inc[4] = int'(wh);
      inc[5] = int'(wm);
      clr = clr_wen & clr_wdata;
      @(posedge clk);
      #1;
      if (cke) begin
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               for (int i = 0; i < 6; i++) begin
                  m_cnt[k][i] = 64'd0;
                  m_rd[k][i]  = 32'd0;
               end
               m_rv[k]  = 6'd0;
               m_rdy[k] = 1'b0;
            end else begin
               m_rdy[k] = 1'b1;
               m_rv[k]  = ren;
               for (int i = 0; i < 6; i++) begin
                  if (ren[i]) m_rd[k][i] = 32'(m_cnt[k][i]);
                  m_cnt[k][i] = clr ? 64'd0 : model_add(m_cnt[k][i], inc[i], m_w[k]);
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) begin
            check($sformatf("w%0d_rvalid%0d", m_w[k], i), {31'd0, d_rv[k][i]}, {31'd0, m_rv[k][i]});
            check($sformatf("w%0d_rdata%0d", m_w[k], i), d_rd[k][i], m_rd[k][i]);
            check($sformatf("w%0d_rready%0d", m_w[k], i), {31'd0, d_rr[k][i]}, {31'd0, m_rdy[k]});
         end
         check($sformatf("w%0d_wready", m_w[k]), {31'd0, d_wr[k]}, {31'd0, m_rdy[k]});
      end
   endtask

   task automatic ev(input logic a, input logic b, input logic c, input logic d, input int n);
      rh = a; rm = b; wh = c; wm = d;
      repeat (n) step();
      rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
   endtask

   task automatic rd(input logic [5:0] m);
      ren = m;
      step();
      ren = 6'd0;
   endtask

   task automatic clear();
      clr_wen = 1'b1; clr_wdata = 1'b1;
      step();
      clr_wen = 1'b0; clr_wdata = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_ovf;
      logic [31:0] exp_ovf2;
      cke = 1'b1; rst_n = 1'b0;
      rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
      clr_wen = 1'b0; clr_wdata = 1'b0; ren = 6'd0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) begin
            m_cnt[k][i] = 64'd0;
            m_rd[k][i]  = 32'd0;
         end
         m_rv[k] = 6'd0; m_rdy[k] = 1'b0;
      end

      // Reset
      step(); step();
      check("rst_rready", {26'd0, d_rr[0]}, 32'd0);
      rst_n = 1'b1;
      rd(6'h3f);
      check("rst_rd_rvalid", {26'd0, d_rv[0]}, 32'h3f);
      check("rst_rd_rdata", d_rd[0][1], 32'd0);
      check("rst_ready", {26'd0, d_rr[0]}, 32'h3f);
      step();
      check("rvalid_pulse", {26'd0, d_rv[0]}, 32'd0);

      // Counting, non-overlapping pulses
      ev(1'b1, 1'b0, 1'b0, 1'b0, 5);
      ev(1'b0, 1'b1, 1'b0, 1'b0, 3);
      ev(1'b0, 1'b0, 1'b1, 1'b0, 4);
      ev(1'b0, 1'b0, 1'b0, 1'b1, 2);
      rd(6'h3f);
      check("cnt_rw_hit", d_rd[0][0], 32'd9);
      check("cnt_rw_miss", d_rd[0][1], 32'd5);
      check("cnt_read_hit", d_rd[0][2], 32'd5);
      check("cnt_read_miss", d_rd[0][3], 32'd3);
      check("cnt_write_hit", d_rd[0][4], 32'd4);
      check("cnt_write_miss", d_rd[0][5], 32'd2);

      // Simultaneous events
      clear();
      ev(1'b1, 1'b1, 1'b1, 1'b1, 10);
      rd(6'h3f);
      check("sim_rw_hit", d_rd[0][0], 32'd20);
      check("sim_rw_miss", d_rd[0][1], 32'd20);
      check("sim_read_hit", d_rd[0][2], 32'd10);
      check("sim_write_miss", d_rd[0][5], 32'd10);

      // Clear racing an event and a read
      clear();
      ev(1'b1, 1'b0, 1'b0, 1'b0, 7);
      rh = 1'b1; clr_wen = 1'b1; clr_wdata = 1'b1; ren = 6'h01;
      step();
      rh = 1'b0; clr_wen = 1'b0; clr_wdata = 1'b0; ren = 6'd0;
      check("clr_race_rdata", d_rd[0][0], 32'd7);
      rd(6'h01);
      check("clr_after_rdata", d_rd[0][0], 32'd0);

      // Strobe with wdata=0 leaves counters alone
      ev(1'b0, 1'b0, 1'b1, 1'b0, 3);
      clr_wen = 1'b1; clr_wdata = 1'b0;
      step();
      clr_wen = 1'b0;
      rd(6'h3f);
      check("wen0_write_hit", d_rd[0][4], 32'd3);
      check("wen0_rw_hit", d_rd[0][0], 32'd3);

      // Overflow of the 4-bit instance's RW_MISS at 14 + 2
      clear();
      ev(1'b0, 1'b1, 1'b0, 1'b1, 7);
      rd(6'h02);
      check("ovf_pre_w4", d_rd[1][1], 32'd14);
      ev(1'b0, 1'b1, 1'b0, 1'b1, 1);
      rd(6'h02);
`ifdef IOB_CACHE_PERF_CNT_SATURATE_EN
      exp_ovf = 32'd15; exp_ovf2 = 32'd15;
`else
      exp_ovf = 32'd0;  exp_ovf2 = 32'd1;
`endif
      check("ovf_w4", d_rd[1][1], exp_ovf);
      check("ovf_w32", d_rd[0][1], 32'd16);
      ev(1'b0, 1'b1, 1'b0, 1'b0, 1);
      rd(6'h02);
      check("ovf2_w4", d_rd[1][1], exp_ovf2);
      check("ovf2_w32", d_rd[0][1], 32'd17);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         cke       = ($urandom_range(0, 9) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         rh        = 1'($urandom);
         rm        = 1'($urandom);
         wh        = 1'($urandom);
         wm        = 1'($urandom);
         ren       = 6'($urandom);
         clr_wen   = ($urandom_range(0, 15) == 0);
         clr_wdata = 1'($urandom);
         step();
      end
      cke = 1'b1; rst_n = 1'b1; clr_wen = 1'b0; clr_wdata = 1'b0;
      ev(1'b0, 1'b0, 1'b0, 1'b0, 1);

      // Reset during a read request
      ev(1'b1, 1'b0, 1'b0, 1'b0, 3);
      ren = 6'h3f; rst_n = 1'b0;
      step();
      ren = 6'd0;
      check("midrd_rvalid", {26'd0, d_rv[0]}, 32'd0);
      check("midrd_rdata", d_rd[0][2], 32'd0);
      check("midrd_rready", {26'd0, d_rr[0]}, 32'd0);
      rst_n = 1'b1;
      step();
      check("midrd_post_rvalid", {26'd0, d_rv[0]}, 32'd0);

      if (fail_cnt != 0) $display("%0d comparisons did not match", fail_cnt);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
